// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT -> iFFT chain.
package fft_pkg;

    localparam int FFT_N  = 8;
    localparam int LOG2_N = 3;
    localparam int DATA_W = 32;

    typedef logic [LOG2_N-1:0] idx_t;

    // Lane k holds sample x[LANE_ORDER[k*3 +: 3]]: x0,x4,x2,x6,x1,x5,x3,x7.
    localparam logic [FFT_N*LOG2_N-1:0] LANE_ORDER = {3'd7, 3'd3, 3'd5, 3'd1,
                                                      3'd6, 3'd2, 3'd4, 3'd0};

    // Reverse the three index bits (lane number -> natural sample index).
    function automatic idx_t bitrev3(input idx_t k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 8-entry sample bank: indexed write, zero fill of the tail from a given index,
// and the whole bank read out in parallel in natural sample order.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  idx_t               wr_idx_i,
    input  logic [W-1:0]       wr_data_i,
    input  logic               fill_en_i,
    input  idx_t               fill_from_i,
    output logic [FFT_N*W-1:0] rd_data_o
);

    logic [W-1:0] mem_q [FFT_N];

    // Storage: a write at wr_idx wins; entries at or above fill_from are zeroed on a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FFT_N; i++) begin
                if (wr_en_i && (wr_idx_i == idx_t'(i))) begin
                    mem_q[i] <= wr_data_i;
                end else if (fill_en_i && (idx_t'(i) >= fill_from_i)) begin
                    mem_q[i] <= '0;
                end else begin
                    mem_q[i] <= mem_q[i];
                end
            end
        end
    end

    // Parallel read in natural order.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < FFT_N; i++) begin
            rd_data_o[i*W +: W] = mem_q[i];
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// Serial-to-frame loader feeding FFT1: ping-pong banks filled one sample per cycle,
// each full frame presented in bit-reversed lane order under valid/ready.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W-1:0]       s_data,
    input  logic               s_flush,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic [FFT_N*W-1:0] frame_data,
    output logic               frame_padded,
    output logic [CNT_W-1:0]   frame_count
);

    logic             run_q;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    idx_t             wr_idx_q, wr_idx_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       pad_q, pad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic             last_s;
    logic             flush_s;
    logic             close_s;
    logic             handoff_s;
    idx_t             fill_from_s;
    logic [FFT_N*W-1:0] bank_rd_s [2];
    logic [FFT_N*W-1:0] sel_rd_s;

    assign s_ready      = run_q && !full_q[wr_bank_q];
    assign frame_valid  = full_q[rd_bank_q];
    assign frame_padded = pad_q[rd_bank_q];
    assign frame_count  = cnt_q;

    // Handshake decode: a flush only closes a frame that has data and is not already
    // being closed by its 8th sample; a sample taken alongside the flush is kept.
    always_comb begin
        accept_s    = s_valid && s_ready;
        last_s      = accept_s && (wr_idx_q == 3'd7);
        flush_s     = s_flush && s_ready && !last_s && (accept_s || (wr_idx_q != 3'd0));
        close_s     = last_s || flush_s;
        handoff_s   = frame_valid && frame_ready;
        fill_from_s = accept_s ? (wr_idx_q + 3'd1) : wr_idx_q;
    end

    // Next-state for pointers, flags and the handoff counter.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        full_d    = full_q;
        pad_d     = pad_q;
        cnt_d     = cnt_q;
        if (handoff_s) begin
            full_d[rd_bank_q] = 1'b0;
            pad_d[rd_bank_q]  = 1'b0;
            rd_bank_d         = !rd_bank_q;
            cnt_d             = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (close_s) begin
            full_d[wr_bank_q] = 1'b1;
            pad_d[wr_bank_q]  = flush_s;
            wr_bank_d         = !wr_bank_q;
            wr_idx_d          = 3'd0;
        end else if (accept_s) begin
            wr_idx_d = wr_idx_q + 3'd1;
        end else begin
            wr_idx_d = wr_idx_q;
        end
    end

    // State registers; run_q holds s_ready low until the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= 3'd0;
            full_q    <= 2'b00;
            pad_q     <= 2'b00;
            cnt_q     <= '0;
        end else begin
            run_q     <= 1'b1;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            full_q    <= full_d;
            pad_q     <= pad_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank #(.W(W)) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en_i     (accept_s && (wr_bank_q == 1'(b))),
            .wr_idx_i    (wr_idx_q),
            .wr_data_i   (s_data),
            .fill_en_i   (flush_s && (wr_bank_q == 1'(b))),
            .fill_from_i (fill_from_s),
            .rd_data_o   (bank_rd_s[b])
        );
    end

    // Output permutation: lane k carries sample bitrev3(k) of the read bank.
    always_comb begin
        sel_rd_s   = rd_bank_q ? bank_rd_s[1] : bank_rd_s[0];
        frame_data = '0;
        for (int k = 0; k < FFT_N; k++) begin
            frame_data[k*W +: W] = sel_rd_s[int'(bitrev3(idx_t'(k)))*W +: W];
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed and randomised checks of the frame loader: tables of per-cycle vectors,
// hand-written back-pressure and reset sequences, and a random scoreboard run.
module tb_fft_frame_loader;

    localparam int W  = 32;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic           s_flush = 1'b0;
    logic           frame_valid;
    logic           frame_ready = 1'b0;
    logic [8*W-1:0] frame_data;
    logic           frame_padded;
    logic [CW-1:0]  frame_count;

    int checks   = 0;
    int failures = 0;

    fft_frame_loader #(.W(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_flush      (s_flush),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_data   (frame_data),
        .frame_padded (frame_padded),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic           v;
        logic [W-1:0]   d;
        logic           f;
        logic           r;
        logic           e_ready;
        logic           e_fv;
        logic           e_pad;
        logic [CW-1:0]  e_cnt;
        logic           chk_lanes;
        logic [8*W-1:0] e_lanes;
    } vec_t;

    vec_t tbl[$];

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [8*W-1:0] lanes8(input int a0, input int a1, input int a2, input int a3,
                                              input int a4, input int a5, input int a6, input int a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic add(input string name, input logic v, input int d, input logic f, input logic r,
                       input logic e_ready, input logic e_fv, input logic e_pad, input int e_cnt,
                       input logic chk_lanes, input logic [8*W-1:0] e_lanes);
        vec_t t;
        t.name = name; t.v = v; t.d = W'(d); t.f = f; t.r = r;
        t.e_ready = e_ready; t.e_fv = e_fv; t.e_pad = e_pad; t.e_cnt = CW'(e_cnt);
        t.chk_lanes = chk_lanes; t.e_lanes = e_lanes;
        tbl.push_back(t);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input logic f, input logic r);
        s_valid = v; s_data = W'(d); s_flush = f; frame_ready = r;
    endtask

    task automatic do_reset;
        drive(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    int             nxt;
    int             hand;
    logic [8*W-1:0] held;
    int             q[$];
    int             acc;
    int             frames;
    int             x[8];
    logic [8*W-1:0] exp_l;

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        #3;
        chkn("rst_fvalid", 32'(frame_valid), 0);
        chkn("rst_sready", 32'(s_ready), 0);
        chkn("rst_count", 32'(frame_count), 0);
        chkw("rst_data", frame_data, '0);
        do_reset;
        chkn("post_rst_sready", 32'(s_ready), 1);

        // ---------------- table: stream 1..8, flush cases ----------------
        for (int i = 1; i <= 7; i++)
            add("t1_fill", 1'b1, i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, '0);
        add("t1_full", 1'b1, 8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, lanes8(1, 5, 3, 7, 2, 6, 4, 8));
        add("t1_hand", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, '0);
        add("t4_s10", 1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, '0);
        add("t4_s20", 1'b1, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, '0);
        add("t4_flush", 1'b1, 30, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, lanes8(10, 0, 30, 0, 20, 0, 0, 0));
        add("t4_hold", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b1, lanes8(10, 0, 30, 0, 20, 0, 0, 0));
        add("t4_hand_eflush", 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, '0);
        add("t4_eflush", 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, '0);
        add("t4_s7", 1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, '0);
        add("t4_lone_flush", 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, lanes8(7, 0, 0, 0, 0, 0, 0, 0));
        add("t4_hand2", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, '0);
        for (int i = 1; i <= 7; i++)
            add("t4_nat_fill", 1'b1, i * 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, '0);
        add("t4_nat_flush", 1'b1, 24, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1,
            lanes8(3, 15, 9, 21, 6, 18, 12, 24));
        add("t4_hand3", 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0, '0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, int'(tbl[i].d), tbl[i].f, tbl[i].r);
            tick;
            chkn({tbl[i].name, "_sready"}, 32'(s_ready), 32'(tbl[i].e_ready));
            chkn({tbl[i].name, "_fvalid"}, 32'(frame_valid), 32'(tbl[i].e_fv));
            if (tbl[i].e_fv)
                chkn({tbl[i].name, "_padded"}, 32'(frame_padded), 32'(tbl[i].e_pad));
            chkn({tbl[i].name, "_count"}, 32'(frame_count), 32'(tbl[i].e_cnt));
            if (tbl[i].chk_lanes)
                chkw({tbl[i].name, "_lanes"}, frame_data, tbl[i].e_lanes);
        end

        // ---------------- continuous 1..24, frame_ready high ----------------
        do_reset;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, i + 1, 1'b0, 1'b1);
            chkn("t2_sready", 32'(s_ready), 1);
            tick;
            chkn("t2_fvalid", 32'(frame_valid), ((i % 8) == 7) ? 1 : 0);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        tick;
        chkn("t2_count", 32'(frame_count), 3);

        // ---------------- back-pressure: stream 1..20 with frame_ready low ----------------
        do_reset;
        nxt = 1;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, nxt, 1'b0, 1'b0);
            if (s_ready) nxt++;
            tick;
        end
        chkn("t3_accepted", nxt - 1, 16);
        chkn("t3_sready_low", 32'(s_ready), 0);
        chkn("t3_fvalid", 32'(frame_valid), 1);
        chkw("t3_frame1", frame_data, lanes8(1, 5, 3, 7, 2, 6, 4, 8));
        held = frame_data;
        for (int c = 0; c < 3; c++) tick;
        chkw("t3_hold", frame_data, held);
        hand = 0;
        for (int c = 0; c < 20 && nxt <= 20; c++) begin
            drive(1'b1, nxt, 1'b0, 1'b1);
            if (frame_valid) begin
                if (hand == 0) chkw("t3_hand1", frame_data, lanes8(1, 5, 3, 7, 2, 6, 4, 8));
                else           chkw("t3_hand2", frame_data, lanes8(9, 13, 11, 15, 10, 14, 12, 16));
                hand++;
            end
            if (s_ready) nxt++;
            tick;
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        chkn("t3_handoffs", hand, 2);
        chkn("t3_resumed", nxt, 21);
        chkn("t3_count", 32'(frame_count), 2);
        chkn("t3_sready_back", 32'(s_ready), 1);

        // ---------------- reset with a full frame and a partial pending ----------------
        do_reset;
        for (int i = 1; i <= 13; i++) begin
            drive(1'b1, i, 1'b0, 1'b0);
            tick;
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        chkn("t5_pending", 32'(frame_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chkn("t5_rst_fvalid", 32'(frame_valid), 0);
        chkn("t5_rst_count", 32'(frame_count), 0);
        tick;
        rst_n = 1'b1;
        tick;
        chkn("t5_sready", 32'(s_ready), 1);
        chkn("t5_fvalid", 32'(frame_valid), 0);
        chkn("t5_count", 32'(frame_count), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 101 + i, 1'b0, 1'b0);
            tick;
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        chkn("t5_clean_fvalid", 32'(frame_valid), 1);
        chkn("t5_clean_pad", 32'(frame_padded), 0);
        chkw("t5_clean_lanes", frame_data, lanes8(101, 105, 103, 107, 102, 106, 104, 108));
        drive(1'b0, 0, 1'b0, 1'b1);
        tick;
        chkn("t5_clean_count", 32'(frame_count), 1);

        // ---------------- random valid/ready, 1000 samples, scoreboard ----------------
        do_reset;
        acc = 0;
        frames = 0;
        nxt = 1000;
        for (int c = 0; c < 8000 && (acc < 1000 || frame_valid); c++) begin
            drive((acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0, nxt, 1'b0, 1'($urandom_range(0, 1)));
            if (frame_valid && frame_ready) begin
                if (q.size() < 8) begin
                    checks++;
                    failures++;
                    $display("FAIL t6_underflow actual=%0d expected=8", q.size());
                end else begin
                    for (int k = 0; k < 8; k++) x[k] = q.pop_front();
                    for (int k = 0; k < 8; k++)
                        exp_l[k*W +: W] = W'(x[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)]);
                    chkw("t6_frame", frame_data, exp_l);
                    chkn("t6_padded", 32'(frame_padded), 0);
                end
                frames++;
            end
            if (s_valid && s_ready) begin
                q.push_back(nxt);
                nxt = nxt + 7;
                acc++;
            end
            tick;
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        chkn("t6_accepted", acc, 1000);
        chkn("t6_frames", frames, 125);
        chkn("t6_leftover", q.size(), 0);
        chkn("t6_count", 32'(frame_count), 125);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
